rv_multicycle_ctrl: RTL and testbench

- Multi-cycle control unit: the next-generation successor to the single-cycle controller.
- Sequences each RV32I instruction through a finite state machine instead of decoding it in one cycle.
- Supports either fixed-latency or ready-handshake memory, selected by parameter.
- Sits between a shared instruction/data memory port and a multi-cycle datapath; reuses the datapath's existing `zero`/`Neg`/`NegU` flags and the `ALUControl`/`ResultSrc`/`data_select` encodings.

---
 rtl/rv_multicycle_ctrl_if.sv | 38 +++
 rtl/rv_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bus for the RV32I multi-cycle control unit.
// master: the controller (drives control strobes, reads IR, flags, ready).
// slave : the datapath/memory side.
interface rv_multicycle_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        Neg;
  logic        NegU;
  logic        mem_ready;

  logic        mem_req;
  logic        adr_src;
  logic        MemWrite;
  logic        ir_write;
  logic        pc_write;
  logic        RegWrite;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  ALUControl;
  logic [1:0]  ResultSrc;
  logic        data_select;
  logic [3:0]  state;
  logic        instret;

  modport master (
    input  instr, zero, Neg, NegU, mem_ready,
    output mem_req, adr_src, MemWrite, ir_write, pc_write, RegWrite,
           alu_src_a, alu_src_b, ALUControl, ResultSrc, data_select,
           state, instret
  );

  modport slave (
    output instr, zero, Neg, NegU, mem_ready,
    input  mem_req, adr_src, MemWrite, ir_write, pc_write, RegWrite,
           alu_src_a, alu_src_b, ALUControl, ResultSrc, data_select,
           state, instret
  );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// RV32I multi-cycle control unit: sequences each instruction through an FSM
// over a shared instruction/data memory port.
// USE_READY=0: accesses finish after MEM_LAT cycles; USE_READY=1: on mem_ready.
// Optional macro RV_TRAP_EN: unknown opcodes park in TRAP until reset;
// otherwise they retire as a 2-cycle NOP (DECODE -> FETCH).
module rv_multicycle_ctrl #(
  parameter int USE_READY = 0,
  parameter int MEM_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  rv_multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXR    = 4'd6,  S_EXI   = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR  = 4'd11,
    S_LUI    = 4'd12, S_AUIPC  = 4'd13, S_TRAP   = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        access;
  logic        done;
  logic        taken;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        unused_instr;

  assign opcode       = bus.instr[6:0];
  assign funct3       = bus.instr[14:12];
  assign funct7b5     = bus.instr[30];
  assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // ALU operation for EXR/EXI; SUB exists only for R-type, SRA/SRAI via funct7[5].
  function automatic logic [3:0] alu_op(input logic is_r, input logic [2:0] f3,
                                        input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  return 4'b0101;
      3'b010:  return 4'b1000;
      3'b011:  return 4'b1001;
      3'b100:  return 4'b0100;
      3'b101:  return f7 ? 4'b0111 : 4'b0110;
      3'b110:  return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  // Access completion and branch condition from the current state and flags.
  always_comb begin
    access = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    if (USE_READY != 0) done = access && bus.mem_ready;
    else                done = access && (wait_q == LAT_LAST);
    wait_d = (USE_READY == 0 && access && !done) ? wait_q + 4'd1 : 4'd0;
    case (funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.Neg;
      3'b101:  taken = !bus.Neg;
      3'b110:  taken = bus.NegU;
      3'b111:  taken = !bus.NegU;
      default: taken = 1'b0;
    endcase
  end

  // Next-state sequencing; waiting access states hold until done.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no path infers a latch.
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (done) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXR;
          OP_I:              state_d = S_EXI;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`ifdef RV_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (done) state_d = S_MEMWB;
      S_MEMWR:  if (done) state_d = S_FETCH;
      S_EXR,
      S_EXI:    state_d = S_ALUWB;
`ifdef RV_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Decoded control outputs; everything is forced low while reset is held.
  always_comb begin
    bus.mem_req     = 1'b0;
    bus.adr_src     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.ir_write    = 1'b0;
    bus.pc_write    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.alu_src_a   = 2'd0;
    bus.alu_src_b   = 2'd0;
    bus.ALUControl  = ALU_ADD;
    bus.ResultSrc   = 2'd0;
    bus.data_select = 1'b0;
    bus.state       = 4'd0;
    bus.instret     = 1'b0;
    if (!reset) begin
      bus.state = state_q;
      case (state_q)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'd2;
          bus.ir_write  = done;
          bus.pc_write  = done;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd1;
`ifndef RV_TRAP_EN
          bus.instret   = (state_d == S_FETCH);
`endif
        end
        S_MEMADR: begin
          bus.alu_src_a = 2'd2;
          bus.alu_src_b = 2'd1;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.adr_src = 1'b1;
        end
        S_MEMWB: begin
          bus.ResultSrc = 2'd1;
          bus.RegWrite  = 1'b1;
          bus.instret   = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.adr_src  = 1'b1;
          bus.MemWrite = 1'b1;
          bus.instret  = done;
        end
        S_EXR: begin
          bus.alu_src_a  = 2'd2;
          bus.ALUControl = alu_op(1'b1, funct3, funct7b5);
        end
        S_EXI: begin
          bus.alu_src_a  = 2'd2;
          bus.alu_src_b  = 2'd1;
          bus.ALUControl = alu_op(1'b0, funct3, funct7b5);
        end
        S_ALUWB: begin
          bus.RegWrite = 1'b1;
          bus.instret  = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a  = 2'd2;
          bus.ALUControl = ALU_SUB;
          bus.pc_write   = taken;
          bus.instret    = 1'b1;
        end
        S_JAL: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd2;
          bus.pc_write  = 1'b1;
          bus.RegWrite  = 1'b1;
          bus.instret   = 1'b1;
        end
        S_JALR: begin
          bus.alu_src_a = 2'd2;
          bus.alu_src_b = 2'd1;
          bus.ResultSrc = 2'd2;
          bus.pc_write  = 1'b1;
          bus.RegWrite  = 1'b1;
          bus.instret   = 1'b1;
        end
        S_LUI: begin
          bus.data_select = 1'b1;
          bus.RegWrite    = 1'b1;
          bus.instret     = 1'b1;
        end
        S_AUIPC: begin
          bus.alu_src_a = 2'd1;
          bus.alu_src_b = 2'd1;
          bus.ResultSrc = 2'd2;
          bus.RegWrite  = 1'b1;
          bus.instret   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl. Four controllers run side by
// side (MEM_LAT 1/3/4 and ready-handshake); one is observed at a time.
module tb_rv_multicycle_ctrl;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXR = 6, S_EXI = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_JAL = 10, S_JALR = 11, S_LUI = 12, S_AUIPC = 13, S_TRAP = 14;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
    logic [1:0] a, b;
    logic [3:0] alu;
    logic [1:0] rs;
    logic       ds;
    logic [3:0] st;
    logic       instret;
  } obs_t;

  typedef struct {
    logic [31:0] ins;
    logic        z, n, nu;
    int          cycles;
    int          last_st;
    logic        pcw, rw;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero, neg, negu, mem_ready;
  logic [1:0]  sel;
  obs_t        obs [4];
  obs_t        o;
  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    rv_multicycle_ctrl_if bus ();
    assign bus.instr     = instr;
    assign bus.zero      = zero;
    assign bus.Neg       = neg;
    assign bus.NegU      = negu;
    assign bus.mem_ready = mem_ready;
    rv_multicycle_ctrl #(
      .USE_READY (g == 3 ? 1 : 0),
      .MEM_LAT   (g == 0 ? 1 : (g == 1 ? 3 : (g == 2 ? 4 : 1)))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
    assign obs[g] = {bus.mem_req, bus.adr_src, bus.MemWrite, bus.ir_write, bus.pc_write,
                     bus.RegWrite, bus.alu_src_a, bus.alu_src_b, bus.ALUControl,
                     bus.ResultSrc, bus.data_select, bus.state, bus.instret};
  end

  assign o = obs[sel];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  function automatic logic [3:0] alu_expect(input logic is_r, input logic [2:0] f3,
                                            input logic f7);
    case (f3)
      3'd0: return (is_r && f7) ? 4'b0001 : 4'b0000;   // SUB / ADD
      3'd1: return 4'b0101;                             // SLL
      3'd2: return 4'b1000;                             // SLT
      3'd3: return 4'b1001;                             // SLTU
      3'd4: return 4'b0100;                             // XOR
      3'd5: return f7 ? 4'b0111 : 4'b0110;              // SRA / SRL
      3'd6: return 4'b0011;                             // OR
      default: return 4'b0010;                          // AND
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                        input logic nu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n;
      3'd5: return !n;
      3'd6: return nu;
      3'd7: return !nu;
      default: return 1'b0;
    endcase
  endfunction

  // Reference model: the expected list of states for one instruction at a
  // fixed latency, then a per-cycle comparison of the observed controller.
  task automatic run_model(input logic [31:0] ins, input logic z, input logic n,
                           input logic nu, input int lat, input string tag);
    logic [6:0] op;
    logic [2:0] f3;
    logic       writes, tkn;
    int         last;
    op = ins[6:0];
    f3 = ins[14:12];
    instr = ins; zero = z; neg = n; negu = nu;
    writes = 1'b0;
    tkn = 1'b0;
    exp_q.delete();
    repeat (lat) exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    case (op)
      OP_LOAD:  begin
        exp_q.push_back(S_MEMADR);
        repeat (lat) exp_q.push_back(S_MEMRD);
        exp_q.push_back(S_MEMWB);
        writes = 1'b1;
      end
      OP_STORE: begin
        exp_q.push_back(S_MEMADR);
        repeat (lat) exp_q.push_back(S_MEMWR);
      end
      OP_R:     begin exp_q.push_back(S_EXR); exp_q.push_back(S_ALUWB); writes = 1'b1; end
      OP_I:     begin exp_q.push_back(S_EXI); exp_q.push_back(S_ALUWB); writes = 1'b1; end
      OP_BR:    begin exp_q.push_back(S_BRANCH); tkn = branch_taken(f3, z, n, nu); end
      OP_JAL:   begin exp_q.push_back(S_JAL);  writes = 1'b1; tkn = 1'b1; end
      OP_JALR:  begin exp_q.push_back(S_JALR); writes = 1'b1; tkn = 1'b1; end
      OP_LUI:   begin exp_q.push_back(S_LUI);   writes = 1'b1; end
      OP_AUIPC: begin exp_q.push_back(S_AUIPC); writes = 1'b1; end
      default: ;
    endcase
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      #2;
      check({tag, " state"}, o.st, exp_q[i]);
      check({tag, " instret"}, o.instret, (i == last));
      check({tag, " mem_req"}, o.mem_req,
            (exp_q[i] == S_FETCH || exp_q[i] == S_MEMRD || exp_q[i] == S_MEMWR));
      check({tag, " MemWrite"}, o.mem_write, (exp_q[i] == S_MEMWR));
      check({tag, " ir_write"}, o.ir_write, (i == lat - 1));
      check({tag, " pc_write"}, o.pc_write, (i == lat - 1) || (i == last && tkn));
      check({tag, " RegWrite"}, o.reg_write, (i == last && writes));
      if (exp_q[i] == S_EXR || exp_q[i] == S_EXI)
        check({tag, " ALUControl"}, o.alu, alu_expect(op == OP_R, f3, ins[30]));
      if (exp_q[i] == S_MEMRD) check({tag, " adr_src"}, o.adr_src, 1);
      if (exp_q[i] == S_MEMWB) check({tag, " ResultSrc"}, o.rs, 1);
      next_cycle();
    end
  endtask

  task automatic rand_instr(input int lat, input string tag);
    logic [6:0]  ops [9];
    int unsigned r;
    int          k;
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    r = $urandom();
    k = $urandom_range(0, 8);
    run_model({r[31:7], ops[k]}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), lat, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [15];
    obs_t t;
    int   cyc, memw;
    logic found;
    obs_t last_o;

    tbl[0]  = '{32'h00500093, 0, 0, 0, 4, S_ALUWB,  0, 1};  // addi
    tbl[1]  = '{32'h002081B3, 0, 0, 0, 4, S_ALUWB,  0, 1};  // add
    tbl[2]  = '{32'h0000A103, 0, 0, 0, 5, S_MEMWB,  0, 1};  // lw
    tbl[3]  = '{32'h0020A023, 0, 0, 0, 4, S_MEMWR,  0, 0};  // sw
    tbl[4]  = '{32'h00208063, 1, 0, 0, 3, S_BRANCH, 1, 0};  // beq taken
    tbl[5]  = '{32'h00209063, 1, 0, 0, 3, S_BRANCH, 0, 0};  // bne, zero=1
    tbl[6]  = '{32'h00209063, 0, 0, 0, 3, S_BRANCH, 1, 0};  // bne, zero=0
    tbl[7]  = '{32'h0020E063, 0, 1, 0, 3, S_BRANCH, 0, 0};  // bltu ignores Neg
    tbl[8]  = '{32'h0020E063, 0, 0, 1, 3, S_BRANCH, 1, 0};  // bltu follows NegU
    tbl[9]  = '{32'h0020D063, 0, 0, 1, 3, S_BRANCH, 1, 0};  // bge, Neg=0
    tbl[10] = '{32'h0020A063, 1, 1, 1, 3, S_BRANCH, 0, 0};  // funct3 010 never taken
    tbl[11] = '{32'h008000EF, 0, 0, 0, 3, S_JAL,    1, 1};  // jal
    tbl[12] = '{32'h000080E7, 0, 0, 0, 3, S_JALR,   1, 1};  // jalr
    tbl[13] = '{32'h000010B7, 0, 0, 0, 3, S_LUI,    0, 1};  // lui
    tbl[14] = '{32'h00001097, 0, 0, 0, 3, S_AUIPC,  0, 1};  // auipc

    // Reset cycle: every controller shows state 0 and no strobes, even with ready high.
    sel = 2'd0; instr = 32'h0; zero = 0; neg = 0; negu = 0;
    reset = 1'b1; mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    #2;
    for (int g = 0; g < 4; g++) check($sformatf("reset_outputs[%0d]", g), obs[g], 0);
    do_reset();

    // addi at MEM_LAT=1: states 0,1,7,8 then back to FETCH.
    run_model(32'h00500093, 0, 0, 0, 1, "addi_lat1");
    #2;
    check("addi_back_to_fetch", o.st, S_FETCH);
    next_cycle();
    do_reset();

    // Table vectors at MEM_LAT=1: cycles per instruction and retire-cycle strobes.
    for (int v = 0; v < 15; v++) begin
      instr = tbl[v].ins; zero = tbl[v].z; neg = tbl[v].n; negu = tbl[v].nu;
      cyc = 0; found = 1'b0; last_o = '0;
      for (int c = 0; c < 20 && !found; c++) begin
        #2;
        cyc++;
        if (o.instret) begin found = 1'b1; last_o = o; end
        next_cycle();
      end
      check($sformatf("vec%0d retired", v), found, 1);
      check($sformatf("vec%0d cycles", v), cyc, tbl[v].cycles);
      check($sformatf("vec%0d retire_state", v), last_o.st, tbl[v].last_st);
      check($sformatf("vec%0d pc_write", v), last_o.pc_write, tbl[v].pcw);
      check($sformatf("vec%0d RegWrite", v), last_o.reg_write, tbl[v].rw);
    end

    // Unknown opcode 0x7F.
    do_reset();
    instr = 32'h0000007F;
    #2; check("op7f fetch", o.st, S_FETCH);
    next_cycle();
    #2; check("op7f decode", o.st, S_DECODE);
`ifdef RV_TRAP_EN
    check("op7f decode_instret", o.instret, 0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      #2;
      check("op7f trap_state", o.st, S_TRAP);
      t = o; t.st = '0;
      check("op7f trap_strobes", t, 0);
      next_cycle();
    end
`else
    check("op7f decode_instret", o.instret, 1);
    next_cycle();
    #2; check("op7f back_to_fetch", o.st, S_FETCH);
    next_cycle();
`endif

    // lw at MEM_LAT=3: FETCH and MEMRD each last 3 cycles.
    sel = 2'd1;
    do_reset();
    run_model(32'h0000A103, 0, 0, 0, 3, "lw_lat3");

    // Randomized instructions at MEM_LAT=1 and MEM_LAT=3.
    sel = 2'd0;
    do_reset();
    for (int k = 0; k < 40; k++) rand_instr(1, "rand_lat1");
    sel = 2'd1;
    do_reset();
    for (int k = 0; k < 40; k++) rand_instr(3, "rand_lat3");

    // Ready handshake: sw with mem_ready withheld 5 cycles in MEMWR.
    sel = 2'd3;
    do_reset();
    instr = 32'h0020A023;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      #2;
      check("rdy fetch_state", o.st, S_FETCH);
      check("rdy fetch_mem_req", o.mem_req, 1);
      check("rdy fetch_ir_write", o.ir_write, (k == 2));
      check("rdy fetch_pc_write", o.pc_write, (k == 2));
      next_cycle();
    end
    mem_ready = 1'b1;   // high outside an access: must not matter
    #2; check("rdy decode", o.st, S_DECODE);
    next_cycle();
    #2; check("rdy memadr", o.st, S_MEMADR);
    next_cycle();
    memw = 0;
    for (int k = 0; k < 6; k++) begin
      mem_ready = (k == 5);
      #2;
      check("rdy memwr_state", o.st, S_MEMWR);
      check("rdy memwr_adr_src", o.adr_src, 1);
      check("rdy memwr_pc_write", o.pc_write, 0);
      check("rdy memwr_instret", o.instret, (k == 5));
      if (o.mem_write) memw++;
      next_cycle();
    end
    mem_ready = 1'b0;
    check("rdy MemWrite_cycles", memw, 6);
    #2; check("rdy back_to_fetch", o.st, S_FETCH);
    next_cycle();

    // Reset in the second MEMWR cycle of a MEM_LAT=4 store.
    sel = 2'd2;
    do_reset();
    instr = 32'h0020A023;
    repeat (6) next_cycle();            // 4 x FETCH, DECODE, MEMADR
    #2;
    check("rst_mid memwr_state", o.st, S_MEMWR);
    check("rst_mid MemWrite", o.mem_write, 1);
    next_cycle();
    reset = 1'b1;
    #2; check("rst_mid gated", o, 0);
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      check("rst_mid fetch_state", o.st, S_FETCH);
      check("rst_mid MemWrite_low", o.mem_write, 0);
      check("rst_mid no_instret", o.instret, 0);
      check("rst_mid ir_write", o.ir_write, (k == 3));
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
